// File: rtl/reservation_station.sv
// rtl/reservation_station.sv - out-of-order reservation station for ALU/branch ops
module reservation_station #(
    parameter int RS_SIZE = 16,
    parameter int NICK_W  = 4,
    parameter int OP_W    = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              iDP_en,
    input  logic [31:0]       iDP_pc,
    input  logic [OP_W-1:0]   iDP_op,
    input  logic [31:0]       iDP_imm,
    input  logic [NICK_W-1:0] iDP_rd_nick,
    input  logic              iDP_rs1_rdy,
    input  logic [31:0]       iDP_rs1_dt,
    input  logic [NICK_W-1:0] iDP_rs1_nick,
    input  logic              iDP_rs2_rdy,
    input  logic [31:0]       iDP_rs2_dt,
    input  logic [NICK_W-1:0] iDP_rs2_nick,
    input  logic              iEX_en,
    input  logic [NICK_W-1:0] iEX_nick,
    input  logic [31:0]       iEX_dt,
    input  logic              iLS_en,
    input  logic [NICK_W-1:0] iLS_nick,
    input  logic [31:0]       iLS_dt,
    input  logic              iROB_clr,
    output logic              oRS_full,
    output logic              oRS_en,
    output logic [31:0]       oRS_pc,
    output logic [OP_W-1:0]   oRS_op,
    output logic [31:0]       oRS_imm,
    output logic [NICK_W-1:0] oRS_rd_nick,
    output logic [31:0]       oRS_rs1_dt,
    output logic [31:0]       oRS_rs2_dt
);
    localparam int IDX_W = $clog2(RS_SIZE);

    logic [RS_SIZE-1:0] busy;
    logic [RS_SIZE-1:0] rs1_rdy;
    logic [RS_SIZE-1:0] rs2_rdy;
    logic [31:0]        e_pc       [RS_SIZE];
    logic [OP_W-1:0]    e_op       [RS_SIZE];
    logic [31:0]        e_imm      [RS_SIZE];
    logic [NICK_W-1:0]  e_rd_nick  [RS_SIZE];
    logic [31:0]        e_rs1_dt   [RS_SIZE];
    logic [NICK_W-1:0]  e_rs1_nick [RS_SIZE];
    logic [31:0]        e_rs2_dt   [RS_SIZE];
    logic [NICK_W-1:0]  e_rs2_nick [RS_SIZE];

    logic             sel_found;
    logic [IDX_W-1:0] sel_idx;
    logic             free_found;
    logic [IDX_W-1:0] free_idx;
    logic             in_rs1_rdy;
    logic [31:0]      in_rs1_dt;
    logic             in_rs2_rdy;
    logic [31:0]      in_rs2_dt;

    assign oRS_full = &busy;

    // Pick the lowest-index fully-ready entry and the lowest-index free slot from registered state
    always_comb begin
        sel_found  = 1'b0;
        sel_idx    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (!sel_found && busy[i] && rs1_rdy[i] && rs2_rdy[i]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
            if (!free_found && !busy[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    // Dispatch bypass: a source produced on a bus this same cycle is stored as already ready
    always_comb begin
        in_rs1_rdy = iDP_rs1_rdy;
        in_rs1_dt  = iDP_rs1_dt;
        in_rs2_rdy = iDP_rs2_rdy;
        in_rs2_dt  = iDP_rs2_dt;
        if (!iDP_rs1_rdy) begin
            if (iEX_en && iEX_nick == iDP_rs1_nick) begin
                in_rs1_rdy = 1'b1;
                in_rs1_dt  = iEX_dt;
            end else if (iLS_en && iLS_nick == iDP_rs1_nick) begin
                in_rs1_rdy = 1'b1;
                in_rs1_dt  = iLS_dt;
            end
        end
        if (!iDP_rs2_rdy) begin
            if (iEX_en && iEX_nick == iDP_rs2_nick) begin
                in_rs2_rdy = 1'b1;
                in_rs2_dt  = iEX_dt;
            end else if (iLS_en && iLS_nick == iDP_rs2_nick) begin
                in_rs2_rdy = 1'b1;
                in_rs2_dt  = iLS_dt;
            end
        end
    end

    // Entry state and issue register: reset, flush, then wake-up, issue and allocate
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy        <= '0;
            rs1_rdy     <= '0;
            rs2_rdy     <= '0;
            oRS_en      <= 1'b0;
            oRS_pc      <= '0;
            oRS_op      <= '0;
            oRS_imm     <= '0;
            oRS_rd_nick <= '0;
            oRS_rs1_dt  <= '0;
            oRS_rs2_dt  <= '0;
        end else if (rdy) begin
            if (iROB_clr) begin
                busy        <= '0;
                oRS_en      <= 1'b0;
                oRS_pc      <= '0;
                oRS_op      <= '0;
                oRS_imm     <= '0;
                oRS_rd_nick <= '0;
                oRS_rs1_dt  <= '0;
                oRS_rs2_dt  <= '0;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (busy[i] && !rs1_rdy[i]) begin
                        if (iEX_en && iEX_nick == e_rs1_nick[i]) begin
                            rs1_rdy[i]  <= 1'b1;
                            e_rs1_dt[i] <= iEX_dt;
                        end else if (iLS_en && iLS_nick == e_rs1_nick[i]) begin
                            rs1_rdy[i]  <= 1'b1;
                            e_rs1_dt[i] <= iLS_dt;
                        end
                    end
                    if (busy[i] && !rs2_rdy[i]) begin
                        if (iEX_en && iEX_nick == e_rs2_nick[i]) begin
                            rs2_rdy[i]  <= 1'b1;
                            e_rs2_dt[i] <= iEX_dt;
                        end else if (iLS_en && iLS_nick == e_rs2_nick[i]) begin
                            rs2_rdy[i]  <= 1'b1;
                            e_rs2_dt[i] <= iLS_dt;
                        end
                    end
                end

                oRS_en <= sel_found;
                if (sel_found) begin
                    busy[sel_idx] <= 1'b0;
                    oRS_pc      <= e_pc[sel_idx];
                    oRS_op      <= e_op[sel_idx];
                    oRS_imm     <= e_imm[sel_idx];
                    oRS_rd_nick <= e_rd_nick[sel_idx];
                    oRS_rs1_dt  <= e_rs1_dt[sel_idx];
                    oRS_rs2_dt  <= e_rs2_dt[sel_idx];
                end else begin
                    oRS_pc      <= '0;
                    oRS_op      <= '0;
                    oRS_imm     <= '0;
                    oRS_rd_nick <= '0;
                    oRS_rs1_dt  <= '0;
                    oRS_rs2_dt  <= '0;
                end

                // The free slot is never the issuing slot, so the two writes never collide
                if (iDP_en && free_found) begin
                    busy[free_idx]       <= 1'b1;
                    e_pc[free_idx]       <= iDP_pc;
                    e_op[free_idx]       <= iDP_op;
                    e_imm[free_idx]      <= iDP_imm;
                    e_rd_nick[free_idx]  <= iDP_rd_nick;
                    rs1_rdy[free_idx]    <= in_rs1_rdy;
                    e_rs1_dt[free_idx]   <= in_rs1_dt;
                    e_rs1_nick[free_idx] <= iDP_rs1_nick;
                    rs2_rdy[free_idx]    <= in_rs2_rdy;
                    e_rs2_dt[free_idx]   <= in_rs2_dt;
                    e_rs2_nick[free_idx] <= iDP_rs2_nick;
                end
            end
        end
    end
endmodule

// File: tb/tb_reservation_station.sv
// tb/tb_reservation_station.sv - randomized and directed bench for reservation_station
module tb_reservation_station;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b1;
    logic        iDP_en = 1'b0;
    logic [31:0] iDP_pc = '0;
    logic [5:0]  iDP_op = '0;
    logic [31:0] iDP_imm = '0;
    logic [3:0]  iDP_rd_nick = '0;
    logic        iDP_rs1_rdy = 1'b0;
    logic [31:0] iDP_rs1_dt = '0;
    logic [3:0]  iDP_rs1_nick = '0;
    logic        iDP_rs2_rdy = 1'b0;
    logic [31:0] iDP_rs2_dt = '0;
    logic [3:0]  iDP_rs2_nick = '0;
    logic        iEX_en = 1'b0;
    logic [3:0]  iEX_nick = '0;
    logic [31:0] iEX_dt = '0;
    logic        iLS_en = 1'b0;
    logic [3:0]  iLS_nick = '0;
    logic [31:0] iLS_dt = '0;
    logic        iROB_clr = 1'b0;
    logic        oRS_full;
    logic        oRS_en;
    logic [31:0] oRS_pc;
    logic [5:0]  oRS_op;
    logic [31:0] oRS_imm;
    logic [3:0]  oRS_rd_nick;
    logic [31:0] oRS_rs1_dt;
    logic [31:0] oRS_rs2_dt;

    reservation_station #(.RS_SIZE(16), .NICK_W(4), .OP_W(6)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .iDP_en(iDP_en), .iDP_pc(iDP_pc), .iDP_op(iDP_op), .iDP_imm(iDP_imm),
        .iDP_rd_nick(iDP_rd_nick),
        .iDP_rs1_rdy(iDP_rs1_rdy), .iDP_rs1_dt(iDP_rs1_dt), .iDP_rs1_nick(iDP_rs1_nick),
        .iDP_rs2_rdy(iDP_rs2_rdy), .iDP_rs2_dt(iDP_rs2_dt), .iDP_rs2_nick(iDP_rs2_nick),
        .iEX_en(iEX_en), .iEX_nick(iEX_nick), .iEX_dt(iEX_dt),
        .iLS_en(iLS_en), .iLS_nick(iLS_nick), .iLS_dt(iLS_dt),
        .iROB_clr(iROB_clr),
        .oRS_full(oRS_full), .oRS_en(oRS_en), .oRS_pc(oRS_pc), .oRS_op(oRS_op),
        .oRS_imm(oRS_imm), .oRS_rd_nick(oRS_rd_nick),
        .oRS_rs1_dt(oRS_rs1_dt), .oRS_rs2_dt(oRS_rs2_dt)
    );

    always #5 clk = ~clk;

    logic [138:0] act;
    assign act = {oRS_en, oRS_pc, oRS_op, oRS_imm, oRS_rd_nick, oRS_rs1_dt, oRS_rs2_dt};

    int checks = 0;
    int errors = 0;

    // Reference model: a table of waiting instructions, issued in slot order
    typedef struct {
        logic        busy;
        logic [31:0] pc;
        logic [5:0]  op;
        logic [31:0] imm;
        logic [3:0]  rd;
        logic        r1;
        logic [31:0] d1;
        logic [3:0]  n1;
        logic        r2;
        logic [31:0] d2;
        logic [3:0]  n2;
    } ent_t;

    ent_t         m [16];
    logic [138:0] exp_out = '0;

    function automatic logic model_full();
        for (int i = 0; i < 16; i++)
            if (!m[i].busy) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [32:0] woke(input logic r, input logic [31:0] d, input logic [3:0] n);
        if (r) return {1'b1, d};
        if (iEX_en && iEX_nick == n) return {1'b1, iEX_dt};
        if (iLS_en && iLS_nick == n) return {1'b1, iLS_dt};
        return {1'b0, d};
    endfunction

    task automatic model_edge();
        ent_t nm [16];
        int   s;
        int   f;
        if (!rst) begin
            for (int i = 0; i < 16; i++) m[i].busy = 1'b0;
            exp_out = '0;
            return;
        end
        if (!rdy) return;
        if (iROB_clr) begin
            for (int i = 0; i < 16; i++) m[i].busy = 1'b0;
            exp_out = '0;
            return;
        end
        nm = m;
        s = -1;
        f = -1;
        for (int i = 0; i < 16; i++) begin
            if (s < 0 && m[i].busy && m[i].r1 && m[i].r2) s = i;
            if (f < 0 && !m[i].busy) f = i;
        end
        for (int i = 0; i < 16; i++) begin
            if (m[i].busy) begin
                {nm[i].r1, nm[i].d1} = woke(m[i].r1, m[i].d1, m[i].n1);
                {nm[i].r2, nm[i].d2} = woke(m[i].r2, m[i].d2, m[i].n2);
            end
        end
        if (s >= 0) begin
            exp_out = {1'b1, m[s].pc, m[s].op, m[s].imm, m[s].rd, m[s].d1, m[s].d2};
            nm[s].busy = 1'b0;
        end else begin
            exp_out = '0;
        end
        if (iDP_en && f >= 0) begin
            nm[f].busy = 1'b1;
            nm[f].pc   = iDP_pc;
            nm[f].op   = iDP_op;
            nm[f].imm  = iDP_imm;
            nm[f].rd   = iDP_rd_nick;
            nm[f].n1   = iDP_rs1_nick;
            nm[f].n2   = iDP_rs2_nick;
            {nm[f].r1, nm[f].d1} = woke(iDP_rs1_rdy, iDP_rs1_dt, iDP_rs1_nick);
            {nm[f].r2, nm[f].d2} = woke(iDP_rs2_rdy, iDP_rs2_dt, iDP_rs2_nick);
        end
        m = nm;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        rdy      = 1'b1;
        iDP_en   = 1'b0;
        iEX_en   = 1'b0;
        iLS_en   = 1'b0;
        iROB_clr = 1'b0;
    endtask

    task automatic set_dp(input logic [31:0] pc, input logic [5:0] op, input logic [31:0] imm,
                          input logic [3:0] rd, input logic r1, input logic [31:0] d1,
                          input logic [3:0] n1, input logic r2, input logic [31:0] d2,
                          input logic [3:0] n2);
        iDP_en       = 1'b1;
        iDP_pc       = pc;
        iDP_op       = op;
        iDP_imm      = imm;
        iDP_rd_nick  = rd;
        iDP_rs1_rdy  = r1;
        iDP_rs1_dt   = d1;
        iDP_rs1_nick = n1;
        iDP_rs2_rdy  = r2;
        iDP_rs2_dt   = d2;
        iDP_rs2_nick = n2;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b0;
        tick();
        tick();
        checks++;
        if (act !== '0 || oRS_full !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold out=%h full=%b required 0/0", act, oRS_full);
        end
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (act !== '0 || oRS_full !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle out=%h full=%b required 0/0", act, oRS_full);
            end
        end
    endtask

    task automatic test_ready_dispatch();
        do_reset();
        set_dp(32'h100, 6'd1, 32'd5, 4'd3, 1'b1, 32'd7, 4'd0, 1'b1, 32'd0, 4'd0);
        tick();
        idle();
        checks++;
        if (oRS_en !== 1'b0) begin
            errors++;
            $display("FAIL ready_edge1 en=%b required 0", oRS_en);
        end
        tick();
        checks++;
        if (act !== {1'b1, 32'h100, 6'd1, 32'd5, 4'd3, 32'd7, 32'd0} || act !== exp_out) begin
            errors++;
            $display("FAIL ready_issue out=%h required %h", act,
                     {1'b1, 32'h100, 6'd1, 32'd5, 4'd3, 32'd7, 32'd0});
        end
        tick();
        checks++;
        if (act !== '0) begin
            errors++;
            $display("FAIL ready_edge3 out=%h required 0", act);
        end
    endtask

    task automatic test_wakeup_bypass();
        do_reset();
        set_dp(32'h140, 6'd2, 32'd0, 4'd7, 1'b0, 32'd0, 4'd2, 1'b0, 32'd0, 4'd5);
        tick();
        idle();
        tick();
        tick();
        iEX_en = 1'b1; iEX_nick = 4'd2; iEX_dt = 32'h11;
        tick();
        idle();
        tick();
        iLS_en = 1'b1; iLS_nick = 4'd5; iLS_dt = 32'h22;
        tick();
        idle();
        checks++;
        if (oRS_en !== 1'b0 || act !== exp_out) begin
            errors++;
            $display("FAIL wake_not_early en=%b required 0", oRS_en);
        end
        tick();
        checks++;
        if (oRS_en !== 1'b1 || oRS_pc !== 32'h140 || oRS_rs1_dt !== 32'h11 ||
            oRS_rs2_dt !== 32'h22 || act !== exp_out) begin
            errors++;
            $display("FAIL wake_issue en=%b pc=%h rs1=%h rs2=%h required 1/140/11/22",
                     oRS_en, oRS_pc, oRS_rs1_dt, oRS_rs2_dt);
        end
        set_dp(32'h180, 6'd3, 32'd1, 4'd8, 1'b0, 32'd0, 4'd9, 1'b1, 32'h44, 4'd0);
        iEX_en = 1'b1; iEX_nick = 4'd9; iEX_dt = 32'h33;
        tick();
        idle();
        tick();
        checks++;
        if (oRS_en !== 1'b1 || oRS_pc !== 32'h180 || oRS_rs1_dt !== 32'h33 ||
            oRS_rs2_dt !== 32'h44) begin
            errors++;
            $display("FAIL bypass_issue en=%b pc=%h rs1=%h rs2=%h required 1/180/33/44",
                     oRS_en, oRS_pc, oRS_rs1_dt, oRS_rs2_dt);
        end
    endtask

    task automatic test_order_fill();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            set_dp(32'h1000 + 32'(i) * 4, 6'd4, 32'(i), 4'(i), 1'b0, 32'd0, 4'(i),
                   1'b1, 32'(i) + 100, 4'd0);
            tick();
        end
        idle();
        checks++;
        if (oRS_full !== 1'b1) begin
            errors++;
            $display("FAIL fill_full full=%b required 1", oRS_full);
        end
        set_dp(32'hDEAD, 6'd5, 32'd0, 4'd0, 1'b1, 32'd1, 4'd0, 1'b1, 32'd2, 4'd0);
        tick();
        idle();
        tick();
        checks++;
        if (oRS_full !== 1'b1 || oRS_en !== 1'b0 || act !== exp_out) begin
            errors++;
            $display("FAIL fill_ignore17 full=%b en=%b required 1/0", oRS_full, oRS_en);
        end
        iEX_en = 1'b1; iEX_nick = 4'd1; iEX_dt = 32'hA1;
        iLS_en = 1'b1; iLS_nick = 4'd3; iLS_dt = 32'hA3;
        tick();
        idle();
        tick();
        checks++;
        if (oRS_en !== 1'b1 || oRS_pc !== 32'h1004 || oRS_rs1_dt !== 32'hA1 ||
            oRS_full !== 1'b0 || act !== exp_out) begin
            errors++;
            $display("FAIL order_first en=%b pc=%h rs1=%h full=%b required 1/1004/a1/0",
                     oRS_en, oRS_pc, oRS_rs1_dt, oRS_full);
        end
        tick();
        checks++;
        if (oRS_en !== 1'b1 || oRS_pc !== 32'h100C || oRS_rs1_dt !== 32'hA3 ||
            oRS_rs2_dt !== 32'd103) begin
            errors++;
            $display("FAIL order_second en=%b pc=%h rs1=%h rs2=%h required 1/100c/a3/67",
                     oRS_en, oRS_pc, oRS_rs1_dt, oRS_rs2_dt);
        end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            set_dp(32'h2000 + 32'(i), 6'd6, 32'd0, 4'(i), 1'b0, 32'd0, 4'(i),
                   1'b1, 32'd0, 4'd0);
            tick();
        end
        set_dp(32'h2100, 6'd7, 32'd0, 4'd6, 1'b1, 32'd9, 4'd0, 1'b1, 32'd9, 4'd0);
        tick();
        set_dp(32'h2200, 6'd7, 32'd0, 4'd7, 1'b1, 32'd8, 4'd0, 1'b1, 32'd8, 4'd0);
        iROB_clr = 1'b1;
        tick();
        idle();
        checks++;
        if (oRS_en !== 1'b0 || oRS_full !== 1'b0 || act !== '0) begin
            errors++;
            $display("FAIL flush_clear en=%b full=%b out=%h required 0/0/0", oRS_en, oRS_full, act);
        end
        for (int k = 0; k < 8; k++) begin
            iEX_en = 1'b1; iEX_nick = 4'(2 * k);     iEX_dt = 32'h55;
            iLS_en = 1'b1; iLS_nick = 4'(2 * k + 1); iLS_dt = 32'h66;
            tick();
            checks++;
            if (oRS_en !== 1'b0) begin
                errors++;
                $display("FAIL flush_after en=%b pc=%h required en 0", oRS_en, oRS_pc);
            end
        end
        idle();
    endtask

    task automatic test_stall();
        do_reset();
        set_dp(32'h200, 6'd8, 32'd1, 4'd1, 1'b1, 32'd10, 4'd0, 1'b1, 32'd11, 4'd0);
        tick();
        set_dp(32'h204, 6'd8, 32'd2, 4'd2, 1'b1, 32'd20, 4'd0, 1'b1, 32'd21, 4'd0);
        tick();
        rdy = 1'b0;
        set_dp(32'h300, 6'd9, 32'd3, 4'd3, 1'b1, 32'd30, 4'd0, 1'b1, 32'd31, 4'd0);
        iEX_en = 1'b1; iEX_nick = 4'd4; iEX_dt = 32'h77;
        iROB_clr = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (oRS_en !== 1'b1 || oRS_pc !== 32'h200 || oRS_rs1_dt !== 32'd10 || act !== exp_out) begin
                errors++;
                $display("FAIL stall_hold en=%b pc=%h rs1=%h required 1/200/a", oRS_en, oRS_pc, oRS_rs1_dt);
            end
        end
        idle();
        tick();
        checks++;
        if (oRS_en !== 1'b1 || oRS_pc !== 32'h204 || oRS_rs2_dt !== 32'd21) begin
            errors++;
            $display("FAIL stall_resume en=%b pc=%h rs2=%h required 1/204/15", oRS_en, oRS_pc, oRS_rs2_dt);
        end
        tick();
        checks++;
        if (oRS_en !== 1'b0 || oRS_full !== 1'b0) begin
            errors++;
            $display("FAIL stall_ignored_dp en=%b pc=%h required en 0", oRS_en, oRS_pc);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            rdy      = ($urandom % 10) != 0;
            iROB_clr = ($urandom % 80) == 0;
            iDP_en   = !model_full() && ($urandom % 3 != 0);
            iDP_pc   = $urandom;
            iDP_op   = 6'($urandom);
            iDP_imm  = $urandom;
            iDP_rd_nick  = 4'($urandom);
            iDP_rs1_rdy  = $urandom % 2;
            iDP_rs1_dt   = $urandom;
            iDP_rs1_nick = 4'($urandom % 8);
            iDP_rs2_rdy  = $urandom % 2;
            iDP_rs2_dt   = $urandom;
            iDP_rs2_nick = 4'($urandom % 8);
            iEX_en   = $urandom % 2;
            iEX_nick = 4'($urandom % 8);
            iEX_dt   = $urandom;
            iLS_en   = $urandom % 2;
            iLS_nick = 4'($urandom % 8);
            iLS_dt   = (iLS_nick == iEX_nick) ? iEX_dt : $urandom;
            tick();
            checks++;
            if (act !== exp_out || oRS_full !== model_full()) begin
                errors++;
                $display("FAIL random cyc=%0d out=%h full=%b required %h/%b",
                         c, act, oRS_full, exp_out, model_full());
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_ready_dispatch();
        test_wakeup_bypass();
        test_order_fill();
        test_flush();
        test_stall();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
